uart_led_scheduler: RTL and testbench
=====================================

// Module: uart_led_scheduler
// PURPOSE
//   Avalon-MM master that owns the 3-bit LED PIO slave (s1) in the UART system.
//   Composes the LED value from three sources: heartbeat, RX activity, TX activity.
//   A host manual override from the UART command decoder replaces that value.
//   Writes the PIO only on a value change, or once after reset; single-cycle write strobes.
// PARAMETERS
//   HB_DIV    25000000  heartbeat half-period in clk cycles (0.5 s at 50 MHz); >=2
//   STRETCH   2500000   activity pulse stretch length in clk cycles; >=1
// PORTS
//   clk             in   1   system clock; single clock domain
//   reset           in   1   synchronous, active-high reset
//   rx_pulse        in   1   1-cycle pulse per received byte
//   tx_pulse        in   1   1-cycle pulse per transmitted byte
//   req_valid       in   1   host override request valid
//   req_ready       out  1   high only in IDLE; transfer on valid&&ready
//   req_manual      in   1   1 = hold req_value; 0 = return to auto mode
//   req_value       in   3   manual LED value
//   pio_address     out  2   PIO address; always 0
//   pio_chipselect  out  1   PIO chipselect
//   pio_write_n     out  1   PIO write strobe, active-low
//   pio_writedata   out  32  {29'b0, value}
//   pio_readdata    in   32  PIO readdata; used only with readback
//   led_state       out  3   last value written to PIO
//   err             out  1   sticky readback mismatch flag
// BEHAVIOUR
//   Reset: all outputs registered and cleared.
//     chipselect=0, write_n=1, address=0, writedata=0, led_state=0, err=0.
//     Heartbeat bit, counters and manual mode all cleared; state=SYNC.
//   Heartbeat counter: counts 0..HB_DIV-1; hb toggles when it wraps to 0.
//   Stretch counters: one per rx/tx; a pulse loads STRETCH.
//     Pulse during an active stretch reloads the counter (restarts).
//     The bit is high while the count is non-zero.
//     A pulse and expiry in the same cycle: reload wins.
//   auto = {tx_act, rx_act, hb}; composed = manual ? man_val : auto.
//   Override handshake: on valid&&ready, latch manual<=req_manual and man_val<=req_value.
//     The change affects composed on the next cycle.
//   FSM:
//     SYNC  -> WRITE unconditionally; forces PIO to match after reset.
//     IDLE  -> WRITE when composed != led_state; req_ready=1 only here.
//     WRITE -> 1 cycle: chipselect=1, write_n=0, writedata=composed snapshot.
//              led_state <= snapshot; -> IDLE (or -> READ with readback).
//   Latency: composed change in cycle N -> write strobe in cycle N+1.
//     led_state updates at the end of the write cycle.
//   Changes during WRITE: caught by the IDLE compare, so no value is lost.
//     Intermediate values may be coalesced.
//   Reset mid-write: strobe drops in the reset cycle, then SYNC rewrites the value.
//   The PIO has no waitrequest, so every access completes in one cycle.
// CONFIGURATION
//   UART_LED_SCHED_READBACK_EN defined:
//     WRITE -> READ: chipselect=1, write_n=1 for 1 cycle.
//     -> CHECK: compare registered readdata[2:0] to led_state; mismatch sets err.
//     err clears only on reset; then -> IDLE.
//   Undefined: READ/CHECK states absent, err tied 0, pio_readdata ignored.
// STRUCTURE
//   Package uart_led_pkg: state enum (SYNC, IDLE, WRITE, READ, CHECK).
//     Also LED_W=3 and PIO_DATA_ADDR=2'd0.
//   Sub-module uart_led_stretch: one stretch counter (pulse in, active out).
//     Instantiated twice, once for rx and once for tx.
// TESTING  (HB_DIV=8, STRETCH=4)
//   Reset release -> one write of 3'b000 within 2 cycles, then IDLE.
//     req_ready=1.
//   No activity -> writes alternate 001/000 every 8 cycles.
//     Each write strobe lasts exactly 1 cycle.
//   rx_pulse at t, second pulse at t+2 -> bit1 high from t+1 to t+6.
//     One rising write and one falling write only.
//   Manual request value=3'b101 -> single write 101.
//     Heartbeat and pulses cause no writes.
//     Then manual=0 -> auto value written next.
//   req_valid asserted during WRITE -> req_ready=0; accepted in next IDLE cycle.
//   READBACK_EN with pio_readdata forced to 0 after a write of 001 -> err=1 and sticky.
//     With a correct readback, err stays 0.

Source files
------------

// File: rtl/uart_led_pkg.sv
// Shared types and constants for the LED PIO scheduler.
//   state_e        scheduler FSM states
//   LED_W          width of the LED field in the PIO data word
//   PIO_DATA_ADDR  PIO data register address
package uart_led_pkg;

  localparam int         LED_W         = 3;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    WRITE,
    READ,
    CHECK
  } state_e;

endpackage

// File: rtl/uart_led_stretch.sv
// Activity pulse stretcher: a 1-cycle pulse holds active_o high for STRETCH
// cycles. A pulse during an active stretch restarts it, and a pulse arriving
// on the expiry cycle takes priority over the expiry.
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   pulse_i   1-cycle activity pulse
//   active_o  high while the stretch count is non-zero
module uart_led_stretch
  import uart_led_pkg::*;
#(
  parameter int STRETCH = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_i,
  output logic active_o
);

  localparam int                CNT_W = $clog2(STRETCH + 1);
  localparam logic [CNT_W-1:0]  LOAD  = CNT_W'(STRETCH);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pulse_i) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active_o = (cnt_q != '0);

endmodule

// File: rtl/uart_led_scheduler.sv
// Avalon-MM master owning the 3-bit LED PIO. The LED value is composed from a
// heartbeat and stretched RX/TX activity, or replaced by a host manual value.
// The PIO is written only when the composed value differs from the last value
// written, plus once after reset.
// Optional build macro: UART_LED_SCHED_READBACK_EN adds a read-back after each
// write and a sticky err flag on mismatch; otherwise err is 0 and pio_readdata
// is ignored.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   rx_pulse/tx_pulse 1-cycle activity pulses
//   req_valid/ready   host override handshake (ready only in IDLE)
//   req_manual/value  1 = hold value, 0 = back to auto
//   pio_*             Avalon-MM master towards the PIO slave s1
//   led_state         last value written to the PIO
//   err               sticky read-back mismatch flag
//
// state | meaning
// SYNC  | after reset; unconditionally rewrites the PIO
// IDLE  | waiting for composed value to differ from led_state
// WRITE | single-cycle write strobe with the snapshot value
// READ  | single-cycle read of the PIO (read-back builds only)
// CHECK | compare read data with led_state (read-back builds only)
module uart_led_scheduler
  import uart_led_pkg::*;
#(
  parameter int HB_DIV  = 25000000,
  parameter int STRETCH = 2500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_pulse,
  input  logic             tx_pulse,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_manual,
  input  logic [LED_W-1:0] req_value,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  output logic [LED_W-1:0] led_state,
  output logic             err
);

  localparam int               HB_W    = $clog2(HB_DIV);
  localparam logic [HB_W-1:0]  HB_LAST = HB_W'(HB_DIV - 1);

  logic [HB_W-1:0]  hb_cnt_q, hb_cnt_d;
  logic             hb_q, hb_d;
  logic             rx_act, tx_act;
  logic             manual_q;
  logic [LED_W-1:0] man_val_q;
  logic [LED_W-1:0] composed;

  state_e           state_q;
  logic             cs_q, write_n_q, ready_q, err_q;
  logic [LED_W-1:0] wdata_q, led_q;

  always_comb begin
    hb_cnt_d = (hb_cnt_q == HB_LAST) ? '0 : hb_cnt_q + HB_W'(1);
    hb_d     = hb_q ^ (hb_cnt_q == HB_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  uart_led_stretch #(.STRETCH(STRETCH)) u_rx_stretch (
    .clk      (clk),
    .reset    (reset),
    .pulse_i  (rx_pulse),
    .active_o (rx_act)
  );

  uart_led_stretch #(.STRETCH(STRETCH)) u_tx_stretch (
    .clk      (clk),
    .reset    (reset),
    .pulse_i  (tx_pulse),
    .active_o (tx_act)
  );

  // ready_q is high exactly in IDLE, so this is the valid&&ready transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      manual_q  <= 1'b0;
      man_val_q <= '0;
    end else if (req_valid && ready_q) begin
      manual_q  <= req_manual;
      man_val_q <= req_value;
    end
  end

  assign composed = manual_q ? man_val_q : {tx_act, rx_act, hb_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SYNC;
      cs_q      <= 1'b0;
      write_n_q <= 1'b1;
      wdata_q   <= '0;
      led_q     <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        SYNC: begin
          state_q   <= WRITE;
          cs_q      <= 1'b1;
          write_n_q <= 1'b0;
          wdata_q   <= composed;
          ready_q   <= 1'b0;
        end
        IDLE: begin
          if (composed != led_q) begin
            state_q   <= WRITE;
            cs_q      <= 1'b1;
            write_n_q <= 1'b0;
            wdata_q   <= composed;
            ready_q   <= 1'b0;
          end
        end
        WRITE: begin
          write_n_q <= 1'b1;
          led_q     <= wdata_q;
`ifdef UART_LED_SCHED_READBACK_EN
          state_q   <= READ;
          cs_q      <= 1'b1;
`else
          state_q   <= IDLE;
          cs_q      <= 1'b0;
          ready_q   <= 1'b1;
`endif
        end
`ifdef UART_LED_SCHED_READBACK_EN
        READ: begin
          state_q <= CHECK;
          cs_q    <= 1'b0;
        end
        CHECK: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
`endif
        default: begin
          state_q   <= SYNC;
          cs_q      <= 1'b0;
          write_n_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_LED_SCHED_READBACK_EN
  logic [LED_W-1:0] rdata_q;
  logic             unused_rd_hi;

  assign unused_rd_hi = ^pio_readdata[31:LED_W];

  // Read data is registered at the end of READ and compared in CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == READ) begin
        rdata_q <= pio_readdata[LED_W-1:0];
      end
      if ((state_q == CHECK) && (rdata_q != led_q)) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_rd;

  assign unused_rd = ^pio_readdata;
  assign err_q     = 1'b0;
`endif

  assign req_ready      = ready_q;
  assign pio_address    = PIO_DATA_ADDR;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = write_n_q;
  assign pio_writedata  = {{(32 - LED_W){1'b0}}, wdata_q};
  assign led_state      = led_q;
  assign err            = err_q;

endmodule

// File: tb/tb_uart_led_scheduler.sv
// Randomized bench for uart_led_scheduler (HB_DIV=8, STRETCH=4). A cycle-indexed
// reference model predicts the LED value from pulse timestamps, heartbeat
// arithmetic and the override history, and predicts when each write occurs.
module tb_uart_led_scheduler;

  localparam int HB = 8;
  localparam int ST = 4;
`ifdef UART_LED_SCHED_READBACK_EN
  localparam int RB_EXTRA = 2;
`else
  localparam int RB_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_pulse = 1'b0, tx_pulse = 1'b0;
  logic        req_valid = 1'b0, req_manual = 1'b0;
  logic [2:0]  req_value = 3'd0;
  logic        req_ready;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n;
  logic [31:0] pio_writedata, pio_readdata;
  logic [2:0]  led_state;
  logic        err;

  logic [2:0]  pio_reg = 3'd0;
  logic        corrupt = 1'b0;

  uart_led_scheduler #(.HB_DIV(HB), .STRETCH(ST)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_pulse       (rx_pulse),
    .tx_pulse       (tx_pulse),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_manual     (req_manual),
    .req_value      (req_value),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .led_state      (led_state),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Simple PIO slave; upper readdata bits are junk to exercise the masking.
  always @(posedge clk) begin
    if (pio_chipselect && !pio_write_n) pio_reg <= pio_writedata[2:0];
  end
  assign pio_readdata = corrupt ? 32'd0 : {29'h15555555, pio_reg};

  int errors = 0;
  int checks = 0;

  // model state
  int         c;
  int         last_rx, last_tx;
  int         wr_cycle, idle_from, err_at;
  logic       manual_m, err_m;
  logic [2:0] man_val_m, led_m, wr_val;
  int         strobes_seen;

  // stimulus for the next step
  logic       d_rx, d_tx, d_valid, d_manual;
  logic [2:0] d_value;
  logic       accepted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  function automatic logic [2:0] model_led();
    logic hb, rx, tx;
    hb = ((c / HB) % 2) == 1;
    rx = (c - last_rx >= 1) && (c - last_rx <= ST);
    tx = (c - last_tx >= 1) && (c - last_tx <= ST);
    return manual_m ? man_val_m : {tx, rx, hb};
  endfunction

  // Check outputs of cycle c, drive cycle-c inputs, advance model and clock.
  task automatic step();
    logic [2:0] comp;
    logic is_wr, is_rd, rdy;
    if (c == err_at) err_m = 1'b1;
    comp  = model_led();
    is_wr = (c == wr_cycle);
    is_rd = (RB_EXTRA != 0) && (c == wr_cycle + 1);
    rdy   = (c >= idle_from);
    check_eq("chipselect", 32'(pio_chipselect), 32'(is_wr || is_rd));
    check_eq("write_n", 32'(pio_write_n), 32'(!is_wr));
    if (is_wr) check_eq("writedata", pio_writedata, {29'd0, wr_val});
    check_eq("address", 32'(pio_address), 32'd0);
    check_eq("req_ready", 32'(req_ready), 32'(rdy));
    check_eq("led_state", 32'(led_state), 32'(led_m));
    check_eq("err", 32'(err), 32'(err_m));
    if (pio_chipselect && !pio_write_n) strobes_seen++;

    rx_pulse   = d_rx;
    tx_pulse   = d_tx;
    req_valid  = d_valid;
    req_manual = d_manual;
    req_value  = d_value;
    accepted   = rdy && d_valid;

    if (is_rd && ((corrupt ? 3'd0 : wr_val) != wr_val)) err_at = c + 2;
    if (is_wr) led_m = wr_val;
    if (accepted) begin
      manual_m  = d_manual;
      man_val_m = d_value;
    end
    if (d_rx) last_rx = c;
    if (d_tx) last_tx = c;
    if (c == 0) begin
      wr_cycle  = 1;
      wr_val    = comp;
      idle_from = 2 + RB_EXTRA;
    end else if (rdy && (comp != led_m)) begin
      wr_cycle  = c + 1;
      wr_val    = comp;
      idle_from = c + 2 + RB_EXTRA;
    end
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic quiet();
    d_rx = 0; d_tx = 0; d_valid = 0; d_manual = 0; d_value = 3'd0;
  endtask

  task automatic do_reset();
    quiet();
    rx_pulse = 0; tx_pulse = 0; req_valid = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_chipselect", 32'(pio_chipselect), 32'd0);
    check_eq("rst_write_n", 32'(pio_write_n), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_writedata", pio_writedata, 32'd0);
    check_eq("rst_led_state", 32'(led_state), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    c = 0; last_rx = -100; last_tx = -100;
    wr_cycle = -10; idle_from = 1 << 30; err_at = -1;
    manual_m = 0; man_val_m = 3'd0; led_m = 3'd0; wr_val = 3'd0; err_m = 0;
    strobes_seen = 0;
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic request(input logic man, input logic [2:0] val);
    d_valid = 1; d_manual = man; d_value = val;
    accepted = 0;
    for (int n = 0; n < 20 && !accepted; n++) step();
    check_eq("req_accept", 32'(accepted), 32'd1);
    quiet();
  endtask

  task automatic wait_write(input int bound);
    for (int n = 0; n < bound && c != wr_cycle; n++) step();
    check_eq("reach_write", c, wr_cycle);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a, n;
    do_reset();

    // idle: SYNC write at 1, heartbeat writes at 9,17,25,33
    run(34);
    check_eq("idle_write_count", strobes_seen, 5);

    // rx pulses at t and t+2
    d_rx = 1; step();
    d_rx = 0; step();
    d_rx = 1; step();
    d_rx = 0; run(12);
    d_tx = 1; step();
    d_tx = 0; run(10);

    // manual 101: no writes from heartbeat or pulses while held
    request(1'b1, 3'b101);
    for (n = 0; n < 10 && led_m != 3'b101; n++) step();
    check_eq("manual_led", 32'(led_state), 32'(3'b101));
    strobes_seen = 0;
    for (int i = 0; i < 30; i++) begin
      d_rx = ($urandom % 3) == 0;
      d_tx = ($urandom % 3) == 0;
      step();
    end
    quiet();
    check_eq("manual_no_writes", strobes_seen, 0);
    request(1'b0, 3'b000);
    run(12);

    // request during WRITE waits for the next IDLE
    wait_write(40);
    d_valid = 1; d_manual = 1; d_value = 3'b011;
    accepted = 0;
    a = 0;
    for (n = 0; n < 10 && !accepted; n++) begin
      step();
      a++;
    end
    quiet();
    check_eq("req_wait_cycles", a, 2 + RB_EXTRA);
    run(6);
    request(1'b0, 3'b000);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      d_rx     = ($urandom % 12) == 0;
      d_tx     = ($urandom % 12) == 0;
      d_valid  = ($urandom % 25) == 0;
      d_manual = ($urandom % 3) != 0;
      d_value  = 3'($urandom);
      step();
    end
    quiet();
    request(1'b0, 3'b000);
    run(10);

    // reset in the middle of a write, then SYNC rewrites
    wait_write(40);
    check_eq("midwrite_strobe", 32'(pio_write_n), 32'd0);
    do_reset();
    run(20);

`ifdef UART_LED_SCHED_READBACK_EN
    request(1'b1, 3'b000);
    run(8);
    corrupt = 1'b1;
    request(1'b1, 3'b001);
    run(10);
    corrupt = 1'b0;
    run(10);
    check_eq("err_sticky", 32'(err), 32'd1);
    do_reset();
    run(10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
